apb_sram_bridge: RTL and testbench
==================================

# apb_sram_bridge

APB3-slave to single-port synchronous SRAM bridge, successor to the fixed 32-bit zero-wait bridge. Adds a programmable SRAM read latency with PREADY wait states, 32- or 64-bit SRAM data width with byte-lane steering, and an address-window check that reports PSLVERR. Sits between the peripheral APB fabric and an on-chip SRAM macro: tightly-coupled data RAM or boot scratchpad.

## Interface
- AW, 32: APB address width.
- M_AW, 13: SRAM window size as byte-address bits (13 = 8 KB).
- M_DW, 32: SRAM data width; legal values are 32 and 64. LB = log2(M_DW/8), i.e. 2 or 3.
- RD_LAT, 1: SRAM read latency in cycles from the CEN-low edge to valid mem_rdata; legal range 1..4.
- BASE, 32'h0: window base address; only bits [AW-1:M_AW] are compared.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- preset  in  1  reset, synchronous, active-high.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  AW  byte address.
- pstrb  in  4  write byte strobes.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- mem_cen  out  1  SRAM chip enable, active-low.
- mem_wen  out  M_DW/8  per-byte write enable, active-low.
- mem_addr  out  M_AW-LB  SRAM word address, equal to paddr[M_AW-1:LB].
- mem_wdata  out  M_DW  write data. For M_DW=64 it is {pwdata,pwdata}.
- mem_rdata  in  M_DW  read data.

## Operation
- Setup phase is psel & ~penable. in_range is true when paddr[AW-1:M_AW] == BASE[AW-1:M_AW].
- SRAM access is issued combinationally in the setup cycle only, and only when in_range is true:
  - mem_cen=0.
  - For a write, mem_wen lanes are cleared where pstrb is set.
  - For M_DW=64, paddr[2] selects lanes [3:0] (paddr[2]=0) or [7:4] (paddr[2]=1). The other lanes stay 1.
- In the setup cycle the bridge registers pwrite, in_range and the lane select lsel = paddr[2] (lsel is 0 for M_DW=32).
- FSM states are IDLE, WR, RD_WAIT, ERR.
  - IDLE: on a setup cycle go to ERR if !in_range, to WR if pwrite, otherwise to RD_WAIT and load cnt = RD_LAT-1.
  - WR: pready=1. Return to IDLE.
  - RD_WAIT: while cnt != 0, pready=0 and cnt decrements. When cnt == 0:
    - pready=1.
    - prdata = lane lsel of mem_rdata (the 32-bit half for M_DW=64).
    - Return to IDLE.
  - ERR: pready=1, pslverr=1, prdata=0, no SRAM access. Return to IDLE.
- prdata is 0 in every cycle that is not a read-completion cycle. pslverr is 0 outside ERR.
- Abort: if psel falls while in RD_WAIT, WR or ERR, the FSM returns to IDLE next cycle.
  - pready is not asserted.
  - Read data still returning from the SRAM is ignored.
- A new setup cycle is only recognised in IDLE. Back-to-back transfers therefore cost setup plus at least one access cycle each, with no extra idle cycle.

## Timing
- Reset (preset=1 at an edge):
  - state=IDLE, cnt=0.
  - pready=0, pslverr=0, prdata=0.
  - mem_cen=1, mem_wen all 1s.
  - preset overrides everything. An in-flight transfer is dropped with no pready, and the mem_cen/mem_wen decode is gated by preset.
- Write: setup at T0 (SRAM written at the T0→T1 edge), pready=1 at T1. No wait states.
- Read: setup at T0, pready=1 and prdata valid at T0+RD_LAT. That is RD_LAT-1 wait states; RD_LAT=1 gives zero wait.
- Error: pready=1 and pslverr=1 at T1, independent of pwrite.
- mem_addr and mem_wdata follow paddr/pwdata combinationally. They are sampled by the SRAM only when mem_cen=0.

## Test plan
- Write then read, M_DW=32, RD_LAT=1:
  - Write 0xDEADBEEF to 0x0000_0010 with pstrb=4'hF: pready at T1, mem_wen=4'h0 and mem_addr=4 in setup.
  - Read back: prdata=0xDEADBEEF at T1, zero wait.
- Byte strobes, M_DW=64:
  - Write 0x11223344 to 0x0000_000C with pstrb=4'b0101: mem_wen=8'b1010_1111, mem_addr=1.
  - Reading 0x0000_000C returns the upper half, lanes [7:4].
- Latency, RD_LAT=3: a read shows pready=0 for 2 access cycles, then pready=1 with correct prdata. Back-to-back reads complete every 4 cycles.
- Out-of-range, M_AW=13 and BASE=0, read of 0x0000_2000: mem_cen stays 1, pready=1 and pslverr=1 at T1, prdata=0. A write to the same address leaves the SRAM unchanged.
- Abort, RD_LAT=4: drop psel in the second wait cycle. No pready; the FSM is in IDLE next cycle; the following write completes normally at T1.
- Reset: assert preset during RD_WAIT. Next cycle all outputs are at their reset values, mem_cen=1, and no spurious pready appears.

Source files
------------

// File: rtl/apb_sram_bridge.sv
// apb_sram_bridge: APB3 slave to single-port synchronous SRAM bridge.
// Programmable SRAM read latency (PREADY wait states), 32/64-bit SRAM width
// with byte-lane steering, and an address-window check reporting PSLVERR.
// Ports:
//   pclk, preset              clock, synchronous active-high reset
//   psel/penable/pwrite       APB control
//   paddr/pstrb/pwdata        APB address, write strobes, write data
//   prdata/pready/pslverr     APB response
//   mem_cen/mem_wen           SRAM chip enable / per-byte write enable (active-low)
//   mem_addr/mem_wdata        SRAM word address / write data
//   mem_rdata                 SRAM read data
module apb_sram_bridge #(
   parameter int unsigned   AW     = 32,
   parameter int unsigned   M_AW   = 13,
   parameter int unsigned   M_DW   = 32,
   parameter int unsigned   RD_LAT = 1,
   parameter logic [AW-1:0] BASE   = '0,
   localparam int unsigned  LB     = (M_DW == 64) ? 3 : 2
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [AW-1:0]       paddr,
   input  logic [3:0]          pstrb,
   input  logic [31:0]         pwdata,
   output logic [31:0]         prdata,
   output logic                pready,
   output logic                pslverr,
   output logic                mem_cen,
   output logic [M_DW/8-1:0]   mem_wen,
   output logic [M_AW-LB-1:0]  mem_addr,
   output logic [M_DW-1:0]     mem_wdata,
   input  logic [M_DW-1:0]     mem_rdata
);

   localparam int unsigned NB = M_DW / 8;
   localparam int unsigned CW = 2;

   typedef enum logic [1:0] {IDLE, WR, RD_WAIT, ERR} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          setup;
   logic          in_range;
   logic          access;
   logic          lane_hi;
   logic          rd_done;
   logic [31:0]   rd_lane;
   logic          unused_addr;

   // Setup phase is only honoured in IDLE; reset gates the SRAM strobe
   assign setup    = psel & ~penable;
   assign in_range = (paddr[AW-1:M_AW] == BASE[AW-1:M_AW]);
   assign access   = ~preset & setup & in_range & (state == IDLE);

   assign mem_cen   = ~access;
   assign mem_addr  = paddr[M_AW-1:LB];
   assign mem_wdata = {(M_DW/32){pwdata}};

   // Byte lanes outside the selected 32-bit half are never written
   for (genvar i = 0; i < NB; i++) begin : g_wen
      assign mem_wen[i] = ~(access & pwrite & pstrb[i % 4] & ((i >= 4) == lane_hi));
   end

   // Half-word select for the 64-bit SRAM; captured at setup for the read return
   if (M_DW == 64) begin : g_w64
      logic lsel;
      always_ff @(posedge pclk) begin
         if (preset)
            lsel <= 1'b0;
         else if (setup && (state == IDLE))
            lsel <= paddr[2];
      end
      assign lane_hi = paddr[2];
      assign rd_lane = lsel ? mem_rdata[63:32] : mem_rdata[31:0];
   end else begin : g_w32
      assign lane_hi = 1'b0;
      assign rd_lane = mem_rdata[31:0];
   end

   assign unused_addr = ^paddr[LB-1:0];

   // Transfer sequencing
   always_ff @(posedge pclk) begin
      if (preset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (setup) begin
                  if (!in_range)
                     state <= ERR;
                  else if (pwrite)
                     state <= WR;
                  else begin
                     state <= RD_WAIT;
                     cnt   <= CW'(RD_LAT - 1);
                  end
               end
            end
            WR, ERR: state <= IDLE;
            RD_WAIT: begin
               if (!psel || (cnt == '0))
                  state <= IDLE;
               else
                  cnt <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Response decoded from the registered state; a dropped psel suppresses it
   assign rd_done = (state == RD_WAIT) && (cnt == '0);
   assign pready  = ~preset & psel & ((state == WR) | (state == ERR) | rd_done);
   assign pslverr = ~preset & psel & (state == ERR);
   assign prdata  = (~preset & psel & rd_done) ? rd_lane : 32'h0;

endmodule

// File: tb/tb_apb_sram_bridge.sv
// Testbench for apb_sram_bridge (M_DW=64, RD_LAT=3): SRAM macro model,
// byte-addressed reference memory, per-cycle output comparison.
module tb_apb_sram_bridge;

   localparam int unsigned AW     = 32;
   localparam int unsigned M_AW   = 13;
   localparam int unsigned M_DW   = 64;
   localparam int unsigned RD_LAT = 3;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel, penable, pwrite;
   logic [31:0] paddr;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        mem_cen;
   logic [7:0]  mem_wen;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   always #5 pclk = ~pclk;

   apb_sram_bridge #(
      .AW(AW), .M_AW(M_AW), .M_DW(M_DW), .RD_LAT(RD_LAT), .BASE(32'h0)
   ) dut (
      .pclk(pclk), .preset(preset),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // SRAM macro: random data on the read port unless a read was issued RD_LAT edges ago
   logic [63:0] sram  [1024];
   logic [63:0] rpipe [RD_LAT];
   always @(posedge pclk) begin
      logic [63:0] rd;
      rd = {$urandom, $urandom};
      if (!mem_cen) begin
         for (int b = 0; b < 8; b++)
            if (!mem_wen[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         if (&mem_wen) rd = sram[mem_addr];
      end
      for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      rpipe[0] <= rd;
   end
   assign mem_rdata = rpipe[RD_LAT-1];

   // Reference memory, byte addressed over the 8 KB window
   logic [7:0] ref_mem [8192];

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int base;
      base = int'({a[12:2], 2'b00});
      return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int base;
      base = int'({a[12:2], 2'b00});
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[base+b] = d[b*8 +: 8];
   endtask

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cyc = 0;
   logic chk_on = 1'b0;

   logic        exp_pready, exp_pslverr, exp_cen, exp_wchk;
   logic [31:0] exp_prdata;
   logic [7:0]  exp_wen;
   logic [9:0]  exp_addr;
   logic [63:0] exp_wdata;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the expectations set by the driver
   always @(negedge pclk) begin
      if (chk_on) begin
         check("pready", 64'(pready), 64'(exp_pready));
         check("pslverr", 64'(pslverr), 64'(exp_pslverr));
         check("prdata", 64'(prdata), 64'(exp_prdata));
         check("mem_cen", 64'(mem_cen), 64'(exp_cen));
         check("mem_wen", 64'(mem_wen), 64'(exp_wen));
         if (!exp_cen) check("mem_addr", 64'(mem_addr), 64'(exp_addr));
         if (exp_wchk) check("mem_wdata", mem_wdata, exp_wdata);
      end
   end

   task automatic set_quiet();
      exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0;
      exp_cen = 1'b1; exp_wen = 8'hFF; exp_wchk = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge pclk); #1;
         psel = 1'b0; penable = 1'b0;
         pwrite = 1'($urandom); paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
         set_quiet();
      end
   endtask

   // One APB transfer; abort_at/reset_at name the access cycle (1-based) to disturb
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int abort_at, input int reset_at,
                       output logic [31:0] got, output logic got_err,
                       output logic [7:0] s_wen, output logic [9:0] s_addr, output logic s_cen);
      logic        inr;
      int          lat;
      int          wb;
      logic [31:0] exp_rd;
      inr    = (addr[31:13] == '0);
      lat    = (!inr || wr) ? 1 : int'(RD_LAT);
      wb     = addr[2] ? 4 : 0;
      exp_rd = model_read(addr);
      got    = '0;
      got_err = 1'b0;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      set_quiet();
      exp_cen = !inr;
      if (wr && inr)
         for (int b = 0; b < 4; b++)
            if (strb[b]) exp_wen[wb+b] = 1'b0;
      exp_addr  = addr[12:3];
      exp_wdata = {data, data};
      exp_wchk  = wr && inr;
      @(negedge pclk);
      s_wen = mem_wen; s_addr = mem_addr; s_cen = mem_cen;
      if (wr && inr) model_write(addr, data, strb);
      for (int k = 1; k <= lat; k++) begin
         @(posedge pclk); #1;
         penable = 1'b1;
         set_quiet();
         if (k == reset_at) begin
            preset = 1'b1;
            @(posedge pclk); #1;
            preset = 1'b0; psel = 1'b0; penable = 1'b0;
            break;
         end
         if (k == abort_at) begin
            psel = 1'b0; penable = 1'b0;
            break;
         end
         exp_pready  = (k == lat);
         exp_pslverr = !inr && (k == lat);
         exp_prdata  = (!wr && inr && (k == lat)) ? exp_rd : 32'h0;
         if (k == lat) begin
            done_cyc = cyc;
            @(negedge pclk);
            got = prdata; got_err = pslverr;
         end
      end
   endtask

   logic [31:0] got, addr, data;
   logic        gerr, s_cen, wr;
   logic [7:0]  s_wen;
   logic [9:0]  s_addr;
   int          d1, d2, ab;

   initial begin
      for (int i = 0; i < 1024; i++) sram[i] = '0;
      for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
      for (int i = 0; i < int'(RD_LAT); i++) rpipe[i] = '0;
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pstrb = '0; pwdata = '0;
      set_quiet();
      @(posedge pclk); #1;
      chk_on = 1'b1;
      repeat (2) @(posedge pclk);
      #1 preset = 1'b0;
      idle(2);

      // Full-word write and read back
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_wr_wen", 64'(s_wen), 64'h0F0);
      check("lit_wr_addr", 64'(s_addr), 64'd2);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_rd_full", 64'(got), 64'hDEADBEEF);

      // Partial strobes into the upper half of word 1
      xfer(1'b1, 32'h0C, 32'h11223344, 4'b0101, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_strb_wen", 64'(s_wen), 64'hAF);
      check("lit_strb_addr", 64'(s_addr), 64'd1);
      idle(1);
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_rd_upper", 64'(got), 64'h00220044);
      xfer(1'b0, 32'h08, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_rd_lower", 64'(got), 64'h0);

      // Outside the window
      xfer(1'b0, 32'h2000, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_oor_rd_cen", 64'(s_cen), 64'd1);
      check("lit_oor_rd_err", 64'(gerr), 64'd1);
      check("lit_oor_rd_data", 64'(got), 64'h0);
      xfer(1'b1, 32'h2000, 32'hA5A5A5A5, 4'hF, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_oor_wr_cen", 64'(s_cen), 64'd1);
      check("lit_oor_wr_err", 64'(gerr), 64'd1);
      xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_oor_untouched", 64'(got), 64'h0);

      // Back-to-back reads: one setup plus RD_LAT access cycles each
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      d1 = done_cyc;
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      d2 = done_cyc;
      check("lit_b2b_period", 64'(d2 - d1), 64'd4);

      // Abort in the second wait cycle, then an immediate write
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 2, 0, got, gerr, s_wen, s_addr, s_cen);
      xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      xfer(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_after_abort", 64'(got), 64'hCAFEF00D);

      // Reset in the middle of a read
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 1, got, gerr, s_wen, s_addr, s_cen);
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, 0, 0, got, gerr, s_wen, s_addr, s_cen);
      check("lit_after_reset", 64'(got), 64'h00220044);

      // Randomized traffic over a small window with occasional misses and aborts
      for (int n = 0; n < 300; n++) begin
         wr   = 1'($urandom);
         addr = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) addr[31:13] = 19'($urandom_range(1, 32'h7FFFF));
         data = $urandom;
         ab   = 0;
         if (!wr && (addr[31:13] == '0) && ($urandom_range(0, 19) == 0))
            ab = int'($urandom_range(1, RD_LAT));
         xfer(wr, addr, data, 4'($urandom), ab, 0, got, gerr, s_wen, s_addr, s_cen);
         idle(int'($urandom_range(0, 2)));
      end

      idle(2);
      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
